asrm_ram_responder: RTL and testbench
=====================================

# asrm_ram_responder

Memory-side responder for the ASRM CPU↔RAM port: word-addressed, single-port synchronous RAM that answers the CPU's `addr`/`data_out`/`write_en` requests and returns read data with one cycle of latency. This latency fits inside the CPU's 2-cycle not-ready window, for both instruction fetch and stack/load/store traffic. The block sits between the CPU core and the top level, and replaces any behavioural RAM model in simulation and synthesis. It adds an optional post-reset clearing sweep and sticky out-of-range error reporting.

## Interface
Parameters:
- `wordsize`, 16, width of data and address buses (same as the CPU).
- `depth_log2`, 10, log2 of implemented words; the implemented words are addresses `0 .. 2^depth_log2-1`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  `wordsize`  word address from the CPU.
- `data_in`  in  `wordsize`  write data (CPU `data_out`).
- `write_en`  in  1  write strobe (CPU `write_en`).
- `data_out`  out  `wordsize`  registered read data (to CPU `data_in`).
- `busy`  out  1  high while the clear sweep runs; the CPU's reset must be held until `busy` is low.
- `oob_error`  out  1  sticky; set by any access with `addr >= 2^depth_log2`.

## Operation
- States: `CLEAR` (only with the config macro) and `SERVE`.
- Reset: `data_out`=0, `oob_error`=0, `clr_ptr`=0.
  - With the macro: state becomes `CLEAR` and `busy`=1.
  - Without the macro: state becomes `SERVE` and `busy`=0.
- `CLEAR` behaviour:
  - Each cycle writes 0 to `mem[clr_ptr]`, then `clr_ptr` increments.
  - When `clr_ptr == 2^depth_log2-1` has been written, the next state is `SERVE` and `busy` drops.
- `CLEAR` and CPU traffic:
  - CPU writes are dropped.
  - `data_out` is held at 0.
  - `oob_error` is not updated.
- `SERVE` read: every cycle, `data_out <= mem[addr]` when in range, else 0.
- `SERVE` write: when `write_en`=1 and in range, `mem[addr] <= data_in`. The read path is write-first, so `data_out <= data_in` on that same edge.
- Out of range (`addr[wordsize-1:depth_log2]` ≠ 0):
  - Read returns 0.
  - Write is ignored.
  - `oob_error` sets on that edge and stays set until `reset`.
- If `depth_log2 >= wordsize`, every address is in range and `oob_error` is tied to 0.
- No byte enables. Full-word access only; the CPU's reduced-behaviour masking is done CPU-side.

## Timing
- Read latency 1:
  - `addr` is sampled at edge N.
  - `data_out` is valid after edge N and held until edge N+1.
  - This meets the CPU, which presents the address at not_ready=2 and latches at not_ready=1.
- Write: takes effect at the edge where `write_en`=1. A read of the same address at edge N+1 returns the new value.
- Back-to-back writes to different addresses on consecutive edges are both committed.
- `reset` during `CLEAR` restarts the sweep at `clr_ptr`=0.
- `reset` during a `SERVE` write: reset wins. The write is dropped and `data_out`=0.
- `CLEAR` duration is exactly `2^depth_log2` cycles after the reset-deasserting edge. `busy` falls on the edge that writes the last word.

## Configuration
- `ASRM_RAM_CLEAR_EN` defined:
  - `CLEAR` state and `clr_ptr` counter are built.
  - After every reset, memory reads as all-zero once `busy` falls.
- `ASRM_RAM_CLEAR_EN` undefined:
  - No `CLEAR` state; `busy` is tied 0.
  - Memory contents survive reset; they are undefined at power-up unless initialised by file.

## Test plan
- Macro off: write 0xBEEF @0x0010, then read 0x0010 next cycle -> `data_out`=0xBEEF one cycle after the address edge.
- Write 0x1234 @0x0005 with `addr` held -> `data_out`=0x1234 after the write edge (write-first).
- `depth_log2`=10: write 0xAAAA @0x0400, then read 0x0400 -> `data_out`=0, `oob_error`=1 and stays 1. Read 0x0000 -> `oob_error` still 1; pulse `reset` -> 0.
- Macro on, `depth_log2`=4: preload 0xFFFF, reset -> `busy` high exactly 16 cycles; then all 16 reads return 0.
- Macro on: assert `reset` at `clr_ptr`=7 -> `busy` stays high 2^depth_log2 cycles from the new release; CPU write 0x5555 @0x0001 during `CLEAR` -> read after `busy` falls returns 0.
- CPU-style sequence: fetch @0x0000 (holds 0x00A3), then load @0x0020 (holds 0x7777) with 2-cycle not-ready spacing -> `data_out` 0x00A3 then 0x7777 at the CPU sample points.

Source files
------------

// File: rtl/asrm_ram_responder.sv
// asrm_ram_responder: word-addressed single-port synchronous RAM answering the
// ASRM CPU. Reads have one cycle of latency and write-first bypass. Out-of-range
// accesses are reported through a sticky error flag.
// Optional feature macro: ASRM_RAM_CLEAR_EN. When it is defined, every reset
// starts a sweep that writes zero to each word, and busy stays high while the
// sweep runs.
module asrm_ram_responder #(
    parameter int wordsize   = 16,
    parameter int depth_log2 = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic                busy,
    output logic                oob_error
);

    localparam int unsigned DEPTH = 1 << depth_log2;

    logic [wordsize-1:0]   mem [DEPTH];
    logic [depth_log2-1:0] idx;
    logic                  in_range;
    logic                  oob_q;
    logic                  serving;
    logic                  mem_we;
    logic [depth_log2-1:0] mem_wa;
    logic [wordsize-1:0]   mem_wd;

    // Address decode. When the memory covers the whole address space, no
    // access can be out of range and the error flag is tied low.
    generate
        if (depth_log2 >= wordsize) begin : g_full
            assign idx       = depth_log2'(addr);
            assign in_range  = 1'b1;
            assign oob_error = 1'b0;
        end else begin : g_part
            assign idx       = addr[depth_log2-1:0];
            assign in_range  = (addr[wordsize-1:depth_log2] == '0);
            assign oob_error = oob_q;
        end
    endgenerate

`ifdef ASRM_RAM_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [0:0]            state;
    logic [depth_log2-1:0] clr_ptr;

    // Clear-sweep sequencer: reset (re)starts the sweep at word 0, and the
    // sweep hands over to SERVE on the edge that writes the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == '1) begin
                state <= ST_SERVE;
            end
        end
    end

    assign serving = (state == ST_SERVE);
    assign busy    = (state == ST_CLEAR);
`else
    assign serving = 1'b1;
    assign busy    = 1'b0;
`endif

    // Write-port select: the sweep owns the port while clearing, CPU writes
    // otherwise. Reset suppresses every write.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = idx;
        mem_wd = data_in;
        if (!reset) begin
`ifdef ASRM_RAM_CLEAR_EN
            if (!serving) begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                mem_wd = '0;
            end else if (write_en && in_range) begin
                mem_we = 1'b1;
            end
`else
            if (write_en && in_range) begin
                mem_we = 1'b1;
            end
`endif
        end
    end

    // Memory array write port (contents are not reset).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Registered read data with write-first bypass, plus the sticky range error.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            oob_q    <= 1'b0;
        end else if (!serving) begin
            data_out <= '0;
        end else if (!in_range) begin
            data_out <= '0;
            oob_q    <= 1'b1;
        end else if (write_en) begin
            data_out <= data_in;
        end else begin
            data_out <= mem[idx];
        end
    end

endmodule

// File: tb/tb_asrm_ram_responder.sv
// tb_asrm_ram_responder: directed self-checking bench for asrm_ram_responder.
// DUT a uses the default geometry (1024 words). DUT b is a 16-word instance,
// which keeps the clear sweep short and makes its range boundary easy to reach.
module tb_asrm_ram_responder;

    logic        clk = 1'b0;
    logic        rst_a, we_a, rst_b, we_b;
    logic [15:0] addr_a, din_a, addr_b, din_b;
    logic [15:0] dout_a, dout_b;
    logic        busy_a, busy_b, oob_a, oob_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    asrm_ram_responder dut_a (
        .clk(clk), .reset(rst_a), .addr(addr_a), .data_in(din_a),
        .write_en(we_a), .data_out(dout_a), .busy(busy_a), .oob_error(oob_a)
    );

    asrm_ram_responder #(.wordsize(16), .depth_log2(4)) dut_b (
        .clk(clk), .reset(rst_b), .addr(addr_b), .data_in(din_b),
        .write_en(we_b), .data_out(dout_b), .busy(busy_b), .oob_error(oob_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle to a sampling point away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for busy to drop on a DUT, within a cycle bound.
    task automatic wait_ready_a();
        for (int i = 0; i < 2000 && busy_a; i++) cycle();
        chk("a_ready", busy_a, 0);
    endtask

    task automatic wait_ready_b();
        for (int i = 0; i < 100 && busy_b; i++) cycle();
        chk("b_ready", busy_b, 0);
    endtask

    // Count the edges from reset release until busy drops on DUT b.
    task automatic count_busy_b(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            n++;
            if (!busy_b) break;
        end
    endtask

    task automatic wr_a(input logic [15:0] a, input logic [15:0] d);
        addr_a = a; din_a = d; we_a = 1'b1;
        cycle();
        we_a = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr_a = a; we_a = 1'b0;
        cycle();
        chk(tag, dout_a, exp);
    endtask

    int n;

    initial begin
        rst_a = 1'b1; we_a = 1'b0; addr_a = '0; din_a = '0;
        rst_b = 1'b1; we_b = 1'b0; addr_b = '0; din_b = '0;
        cycle();
        chk("rst_dout_a", dout_a, 0);
        chk("rst_oob_a", oob_a, 0);
`ifdef ASRM_RAM_CLEAR_EN
        chk("rst_busy_a", busy_a, 1);
`else
        chk("rst_busy_a", busy_a, 0);
`endif
        rst_a = 1'b0; rst_b = 1'b0;
        wait_ready_a();
        wait_ready_b();

        // Write, then read the same word on the next edge.
        addr_a = 16'h0010; din_a = 16'hBEEF; we_a = 1'b1;
        cycle();
        chk("wf_beef", dout_a, 16'hBEEF);
        we_a = 1'b0;
        cycle();
        chk("rd_beef", dout_a, 16'hBEEF);

        // Write-first with the address held.
        addr_a = 16'h0005; din_a = 16'h1234; we_a = 1'b1;
        cycle();
        chk("wf_1234", dout_a, 16'h1234);
        we_a = 1'b0;
        cycle();
        chk("hold_1234", dout_a, 16'h1234);

        // Back-to-back writes to different words, plus the top in-range word.
        wr_a(16'h0000, 16'h00A3);
        wr_a(16'h0020, 16'h7777);
        wr_a(16'h03FF, 16'h1357);
        rd_a("rd_top", 16'h03FF, 16'h1357);
        chk("top_no_oob", oob_a, 0);
        rd_a("rd_5", 16'h0005, 16'h1234);
        rd_a("rd_10", 16'h0010, 16'hBEEF);

        // CPU-style accesses: the address is held for two edges, and the CPU
        // samples after the second edge.
        addr_a = 16'h0000;
        cycle();
        cycle();
        chk("cpu_fetch", dout_a, 16'h00A3);
        addr_a = 16'h0020;
        cycle();
        cycle();
        chk("cpu_load", dout_a, 16'h7777);

        // An out-of-range write reads 0, sets the sticky flag, and must not
        // alias onto word 0.
        addr_a = 16'h0400; din_a = 16'hAAAA; we_a = 1'b1;
        cycle();
        chk("oob_wr_dout", dout_a, 0);
        chk("oob_set", oob_a, 1);
        we_a = 1'b0;
        cycle();
        chk("oob_rd_dout", dout_a, 0);
        rd_a("no_alias", 16'h0000, 16'h00A3);
        chk("oob_sticky", oob_a, 1);

        // Reset wins over a simultaneous write and clears the flag.
        rst_a = 1'b1; addr_a = 16'h0005; din_a = 16'hDEAD; we_a = 1'b1;
        cycle();
        chk("rst_wr_dout", dout_a, 0);
        chk("rst_oob_clr", oob_a, 0);
        rst_a = 1'b0; we_a = 1'b0;
        wait_ready_a();
`ifdef ASRM_RAM_CLEAR_EN
        rd_a("post_rst_5", 16'h0005, 16'h0000);
`else
        rd_a("post_rst_5", 16'h0005, 16'h1234);
`endif

        // Small instance: range boundary at 16 words.
        addr_b = 16'h000F; din_b = 16'hC3C3; we_b = 1'b1;
        cycle();
        we_b = 1'b0;
        cycle();
        chk("b_rd_f", dout_b, 16'hC3C3);
        chk("b_no_oob", oob_b, 0);
        addr_b = 16'h0010;
        cycle();
        chk("b_oob_dout", dout_b, 0);
        chk("b_oob_set", oob_b, 1);

`ifdef ASRM_RAM_CLEAR_EN
        // Preload all ones, reset, and time the sweep. An out-of-range address
        // held during the sweep must leave the flag untouched.
        for (int i = 0; i < 16; i++) begin
            addr_b = 16'(i); din_b = 16'hFFFF; we_b = 1'b1;
            cycle();
        end
        we_b = 1'b0;
        rst_b = 1'b1;
        cycle();
        chk("b_busy_rst", busy_b, 1);
        rst_b = 1'b0; addr_b = 16'h0010;
        count_busy_b(n);
        chk("b_clear_len", n, 16);
        chk("b_clear_oob", oob_b, 0);
        chk("b_clear_dout", dout_b, 0);
        for (int i = 0; i < 16; i++) begin
            addr_b = 16'(i);
            cycle();
            chk("b_cleared", dout_b, 0);
        end

        // A reset in the middle of a sweep restarts it. CPU writes issued
        // during the sweep are dropped.
        for (int i = 0; i < 16; i++) begin
            addr_b = 16'(i); din_b = 16'hFFFF; we_b = 1'b1;
            cycle();
        end
        we_b = 1'b0;
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0;
        repeat (7) cycle();
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0; addr_b = 16'h0001; din_b = 16'h5555; we_b = 1'b1;
        count_busy_b(n);
        we_b = 1'b0;
        chk("b_restart_len", n, 16);
        cycle();
        chk("b_drop_wr", dout_b, 0);
        addr_b = 16'h0009;
        cycle();
        chk("b_rd_9", dout_b, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
